// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite master driven by a simple transfer/ready command port.
// Define AXIL_MASTER_TIMEOUT_EN to enable the busy-state watchdog.
module axi_lite_master #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              transfer,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic [1:0]        resp,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [31:0]       WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [31:0]       RDATA,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [1:0]        RRESP
);
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;
  state_t state, state_n;
  logic aw_ok, w_ok, accept, aw_hs, w_hs, b_hs, r_hs, tmo;
  assign accept = transfer && ready;
  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign b_hs   = BREADY && BVALID;
  assign r_hs   = RREADY && RVALID;
`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) cnt <= '0;
    else cnt <= accept ? '0 : (state != IDLE ? cnt + CW'(1) : cnt);
  assign tmo = (state != IDLE) && (cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT[0];
  assign tmo = 1'b0;
`endif
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:         state_n = accept ? (write ? WR_ADDR_DATA : RD_ADDR) : IDLE;
      WR_ADDR_DATA: state_n = ((aw_ok || aw_hs) && (w_ok || w_hs)) ? WR_RESP : WR_ADDR_DATA;
      WR_RESP:      state_n = BVALID ? IDLE : WR_RESP;
      RD_ADDR:      state_n = ARREADY ? RD_DATA : RD_ADDR;
      RD_DATA:      state_n = RVALID ? IDLE : RD_DATA;
      default:      state_n = IDLE;
    endcase
    if (tmo) state_n = IDLE;
  end
  // VALIDs come only from state and registered handshake flags, never from READY inputs
  always_comb begin
    ready   = state == IDLE;
    AWVALID = (state == WR_ADDR_DATA) && !aw_ok;
    WVALID  = (state == WR_ADDR_DATA) && !w_ok;
    BREADY  = state == WR_RESP;
    ARVALID = state == RD_ADDR;
    RREADY  = state == RD_DATA;
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      aw_ok  <= 1'b0;
      w_ok   <= 1'b0;
      AWADDR <= '0;
      ARADDR <= '0;
      WDATA  <= '0;
      rdata  <= '0;
      resp   <= '0;
      done   <= 1'b0;
    end else begin
      done <= b_hs || r_hs || tmo;
      if (accept) begin
        aw_ok  <= 1'b0;
        w_ok   <= 1'b0;
        AWADDR <= addr;
        ARADDR <= addr;
        WDATA  <= wdata;
      end else begin
        if (aw_hs) aw_ok <= 1'b1;
        if (w_hs) w_ok <= 1'b1;
      end
      if (tmo) resp <= 2'b10;
      else if (b_hs) resp <= BRESP;
      else if (r_hs) begin
        resp  <= RRESP;
        rdata <= RDATA;
      end
    end
endmodule
